// File: rtl/fetch_pc_stage_if.sv
// Fetch/decode boundary bundle: IM data and decode redirect requests in, fetch PC and IF/ID contents out.
// likely_d is present only when BRANCH_LIKELY_EN is defined.
interface fetch_pc_stage_if;
  logic        stall;
  logic [31:0] instr_f;
  logic        cmp_allow;
  logic [15:0] imm16_d;
  logic        j_en;
  logic [25:0] index26_d;
  logic        jr_en;
  logic [31:0] jr_target;
`ifdef BRANCH_LIKELY_EN
  logic        likely_d;
`endif
  logic [31:0] pc_f;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic [31:0] pc8_d;
  logic        pc_misalign_f;

  modport master (
    input  stall, instr_f, cmp_allow, imm16_d, j_en, index26_d, jr_en, jr_target,
`ifdef BRANCH_LIKELY_EN
    input  likely_d,
`endif
    output pc_f, pc_d, instr_d, pc8_d, pc_misalign_f
  );

  modport slave (
    output stall, instr_f, cmp_allow, imm16_d, j_en, index26_d, jr_en, jr_target,
`ifdef BRANCH_LIKELY_EN
    output likely_d,
`endif
    input  pc_f, pc_d, instr_d, pc8_d, pc_misalign_f
  );
endinterface

// File: rtl/fetch_pc_stage.sv
// PC register, next-PC mux and IF/ID register; redirects land in F one cycle after D, stall freezes all state.
// BRANCH_LIKELY_EN: an untaken likely branch annuls its delay slot in IF/ID.
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  fetch_pc_stage_if.master bus
);

  logic [31:0] pc_f_q;
  logic [31:0] pc_d_q;
  logic [31:0] instr_d_q;
  logic [31:0] pc_f4;
  logic [31:0] pc_d4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] npc;
  logic        annul;

  assign pc_f4     = pc_f_q + 32'd4;
  assign pc_d4     = pc_d_q + 32'd4;
  assign br_target = pc_d4 + {{14{bus.imm16_d[15]}}, bus.imm16_d, 2'b00};
  assign j_target  = {pc_d4[31:28], bus.index26_d, 2'b00};

`ifdef BRANCH_LIKELY_EN
  assign annul = bus.likely_d & ~bus.cmp_allow;
`else
  assign annul = 1'b0;
`endif

  // Targets come from pc_d: the word currently in F is the delay slot.
  always_comb begin
    npc = pc_f4;
    if (bus.jr_en)          npc = bus.jr_target;
    else if (bus.j_en)      npc = j_target;
    else if (bus.cmp_allow) npc = br_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q    <= RESET_PC;
      pc_d_q    <= RESET_PC;
      instr_d_q <= NOP_WORD;
    end else if (!bus.stall) begin
      pc_f_q    <= annul ? pc_f4 : npc;
      pc_d_q    <= pc_f_q;
      instr_d_q <= annul ? NOP_WORD : bus.instr_f;
    end
  end

  assign bus.pc_f          = pc_f_q;
  assign bus.pc_d          = pc_d_q;
  assign bus.instr_d       = instr_d_q;
  assign bus.pc8_d         = pc_d_q + 32'd8;
  assign bus.pc_misalign_f = |pc_f_q[1:0];

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: a reference model pushes expected state per cycle, scenario tasks pop and compare.
module tb_fetch_pc_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  fetch_pc_stage_if bus();
  fetch_pc_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t m;
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] im(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Model one edge from the inputs currently driven, queue the result, then advance the clock.
  task automatic tick();
    exp_t        nx;
    logic [31:0] d4, tgt, soff;
    logic        an;
    bus.instr_f = im(m.pc_f);
    d4   = m.pc_d + 32'd4;
    soff = {{16{bus.imm16_d[15]}}, bus.imm16_d};
    an   = 1'b0;
`ifdef BRANCH_LIKELY_EN
    an = bus.likely_d && !bus.cmp_allow;
`endif
    if (bus.jr_en)          tgt = bus.jr_target;
    else if (bus.j_en)      tgt = {d4[31:28], bus.index26_d, 2'b00};
    else if (bus.cmp_allow) tgt = d4 + soff * 4;
    else                    tgt = m.pc_f + 32'd4;
    if (reset) begin
      nx = '{RESET_PC, RESET_PC, NOP_WORD};
    end else if (bus.stall) begin
      nx = m;
    end else begin
      nx.pc_f    = an ? m.pc_f + 32'd4 : tgt;
      nx.pc_d    = m.pc_f;
      nx.instr_d = an ? NOP_WORD : bus.instr_f;
    end
    sb.push_back(nx);
    m = nx;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.cmp_allow = 0; bus.imm16_d = '0; bus.j_en = 0;
    bus.index26_d = '0; bus.jr_en = 0; bus.jr_target = '0;
`ifdef BRANCH_LIKELY_EN
    bus.likely_d = 0;
`endif
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    e = sb.pop_front();
    n_vec++;
    if ({bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL reset_sb got %h want %h", {bus.pc_f, bus.pc_d, bus.instr_d}, e);
    end
    n_vec++;
    if ({bus.pc_f, bus.pc_d, bus.instr_d, bus.pc8_d, bus.pc_misalign_f} !== {RESET_PC, RESET_PC, NOP_WORD, 32'h3008, 1'b0}) begin
      n_err++; $display("FAIL reset_vals got pc_f=%h pc_d=%h instr_d=%h pc8=%h mis=%b", bus.pc_f, bus.pc_d, bus.instr_d, bus.pc8_d, bus.pc_misalign_f);
    end
  endtask

  task automatic test_free_run();
    logic [31:0] want_pc, want_ins;
    for (int i = 1; i < 4; i++) begin
      tick();
      e = sb.pop_front();
      want_pc  = RESET_PC + 32'(4 * i);
      want_ins = im(RESET_PC + 32'(4 * (i - 1)));
      n_vec++;
      if ({bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
        n_err++; $display("FAIL run_sb[%0d] got %h want %h", i, {bus.pc_f, bus.pc_d, bus.instr_d}, e);
      end
      n_vec++;
      if (bus.pc_f !== want_pc || bus.instr_d !== want_ins) begin
        n_err++; $display("FAIL run_seq[%0d] pc_f=%h instr_d=%h want %h %h", i, bus.pc_f, bus.instr_d, want_pc, want_ins);
      end
    end
  endtask

  task automatic test_branch();
    n_vec++;
    if (bus.pc_d !== 32'h3008 || bus.pc8_d !== 32'h3010) begin
      n_err++; $display("FAIL br_link pc_d=%h pc8_d=%h want 3008 3010", bus.pc_d, bus.pc8_d);
    end
    bus.cmp_allow = 1; bus.imm16_d = 16'hFFFE;
    tick();
    clear_inputs();
    e = sb.pop_front();
    n_vec++;
    if ({bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL br_sb got %h want %h", {bus.pc_f, bus.pc_d, bus.instr_d}, e);
    end
    n_vec++;
    if (bus.pc_f !== 32'h3004 || bus.pc_d !== 32'h300C || bus.instr_d !== im(32'h300C)) begin
      n_err++; $display("FAIL br_taken pc_f=%h pc_d=%h instr_d=%h want 3004 300c %h", bus.pc_f, bus.pc_d, bus.instr_d, im(32'h300C));
    end
    tick();
    e = sb.pop_front();
    n_vec++;
    if (bus.pc_f !== 32'h3008 || bus.instr_d !== im(32'h3004) || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL br_target_in_d pc_f=%h instr_d=%h want 3008 %h", bus.pc_f, bus.instr_d, im(32'h3004));
    end
  endtask

  task automatic test_stall_jump();
    bus.jr_en = 1; bus.jr_target = 32'h3010;
    tick();
    bus.jr_target = 32'h3018;
    tick();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      n_vec++;
      if (i == 1 && {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
        n_err++; $display("FAIL setup_sb got %h want %h", {bus.pc_f, bus.pc_d, bus.instr_d}, e);
      end
    end
    bus.j_en = 1; bus.index26_d = 26'h0000C00; bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      n_vec++;
      if (bus.pc_f !== 32'h3018 || bus.pc_d !== 32'h3010 || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
        n_err++; $display("FAIL stall_hold[%0d] pc_f=%h pc_d=%h want 3018 3010", i, bus.pc_f, bus.pc_d);
      end
    end
    bus.stall = 0;
    tick();
    e = sb.pop_front();
    n_vec++;
    if (bus.pc_f !== 32'h3000 || bus.pc_d !== 32'h3018 || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL jump_release pc_f=%h pc_d=%h want 3000 3018", bus.pc_f, bus.pc_d);
    end
    clear_inputs();
    tick();
    e = sb.pop_front();
    n_vec++;
    if (bus.pc_f !== 32'h3004 || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL jump_once pc_f=%h want 3004", bus.pc_f);
    end
  endtask

  task automatic test_jr();
    bus.jr_en = 1; bus.jr_target = 32'h0000_3002; bus.cmp_allow = 1; bus.imm16_d = 16'h0010;
    bus.j_en = 1; bus.index26_d = 26'h0000800;
    tick();
    clear_inputs();
    e = sb.pop_front();
    n_vec++;
    if (bus.pc_f !== 32'h3002 || bus.pc_misalign_f !== 1'b1 || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL jr_prio pc_f=%h mis=%b want 3002 1", bus.pc_f, bus.pc_misalign_f);
    end
    tick();
    e = sb.pop_front();
    n_vec++;
    if (bus.pc_f !== 32'h3006 || bus.pc_misalign_f !== 1'b1 || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL jr_misalign_seq pc_f=%h mis=%b want 3006 1", bus.pc_f, bus.pc_misalign_f);
    end
    bus.jr_en = 1; bus.jr_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    tick();
    e = sb.pop_front();
    e = sb.pop_front();
    n_vec++;
    if (bus.pc_f !== 32'h0 || bus.pc_d !== 32'hFFFF_FFFC || bus.pc8_d !== 32'h4 || bus.pc_misalign_f !== 1'b0
        || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL wrap pc_f=%h pc_d=%h pc8=%h want 0 fffffffc 4", bus.pc_f, bus.pc_d, bus.pc8_d);
    end
  endtask

  task automatic test_reset_priority();
    bus.cmp_allow = 1; bus.imm16_d = 16'h0040; bus.stall = 1;
    reset = 1;
    tick();
    reset = 0;
    clear_inputs();
    e = sb.pop_front();
    n_vec++;
    if ({bus.pc_f, bus.pc_d, bus.instr_d, bus.pc8_d, bus.pc_misalign_f} !== {RESET_PC, RESET_PC, NOP_WORD, 32'h3008, 1'b0}
        || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL reset_prio pc_f=%h pc_d=%h instr_d=%h pc8=%h", bus.pc_f, bus.pc_d, bus.instr_d, bus.pc8_d);
    end
  endtask

`ifdef BRANCH_LIKELY_EN
  task automatic test_likely();
    tick();
    e = sb.pop_front();
    bus.likely_d = 1; bus.stall = 1;
    tick();
    e = sb.pop_front();
    n_vec++;
    if (bus.pc_f !== 32'h3004 || bus.instr_d !== im(32'h3000) || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL likely_stall pc_f=%h instr_d=%h want 3004 %h", bus.pc_f, bus.instr_d, im(32'h3000));
    end
    bus.stall = 0;
    tick();
    e = sb.pop_front();
    n_vec++;
    if (bus.pc_f !== 32'h3008 || bus.pc_d !== 32'h3004 || bus.instr_d !== NOP_WORD || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL likely_annul pc_f=%h pc_d=%h instr_d=%h want 3008 3004 0", bus.pc_f, bus.pc_d, bus.instr_d);
    end
    bus.cmp_allow = 1; bus.imm16_d = 16'h0004;
    tick();
    clear_inputs();
    e = sb.pop_front();
    n_vec++;
    if (bus.pc_f !== 32'h3018 || bus.pc_d !== 32'h3008 || bus.instr_d !== im(32'h3008) || {bus.pc_f, bus.pc_d, bus.instr_d} !== e) begin
      n_err++; $display("FAIL likely_taken pc_f=%h pc_d=%h instr_d=%h want 3018 3008 %h", bus.pc_f, bus.pc_d, bus.instr_d, im(32'h3008));
    end
  endtask
`endif

  initial begin
    m = '0;
    reset = 1;
    clear_inputs();
    bus.instr_f = '0;
    test_reset();
    test_free_run();
    test_branch();
    test_stall_jump();
    test_jr();
    test_reset_priority();
`ifdef BRANCH_LIKELY_EN
    test_likely();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

PC register, next-PC selection and IF/ID pipeline register for the five-stage MIPS pipeline. The branch comparator in D drives `cmp_allow`. This block turns that decision, plus jump and jr requests decoded in D, into the next fetch address. It latches the fetched instruction into D, honouring hazard-unit stalls. The architectural branch delay slot is always fetched.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `NOP_WORD`, 32'h0000_0000, instruction word loaded into IF/ID on reset or annul.

- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID contents.
- `instr_f`  in  32  instruction word read from IM at `pc_f`.
- `cmp_allow`  in  1  branch-taken from the comparator for the instruction in D; 0 for non-branches.
- `imm16_d`  in  16  branch offset field of the instruction in D.
- `j_en`  in  1  instruction in D is j/jal.
- `index26_d`  in  26  jump index field.
- `jr_en`  in  1  instruction in D is jr/jalr.
- `jr_target`  in  32  forwarded rs value for jr.
- `likely_d`  in  1  branch in D is branch-likely; present only with `BRANCH_LIKELY_EN`.
- `pc_f`  out  32  current fetch address; drives IM.
- `pc_d`  out  32  PC of the instruction in D.
- `instr_d`  out  32  instruction in D.
- `pc8_d`  out  32  link address, `pc_d + 8`; combinational.
- `pc_misalign_f`  out  1  `pc_f[1:0] != 0`; combinational.

## Operation
- `npc` selection is combinational, in strict priority order:
  - `jr_en`: `jr_target`.
  - `j_en`: `{pc_d4[31:28], index26_d, 2'b00}`, where `pc_d4 = pc_d + 4`.
  - `cmp_allow`: `pc_d4 + (sext(imm16_d) << 2)`.
  - Otherwise: `pc_f + 4`.
- All additions are modulo 2^32; wrap-around is silent. `0xFFFF_FFFC + 4` gives `0x0000_0000`.
- Redirect targets are computed from `pc_d`, not `pc_f`. The instruction at `pc_f` is the delay slot and always proceeds to D, unless annulled under `BRANCH_LIKELY_EN`.
- The block has two effective states:
  - RUN: `pc_f <= npc`, `pc_d <= pc_f`, `instr_d <= instr_f`.
  - HOLD: entered when `stall=1`; all registers keep their values. HOLD lasts exactly as long as `stall`; there is no extra state.
- Under stall, D is frozen, so the redirect inputs remain valid. The redirect is taken on the first non-stall edge; nothing is lost or taken twice.
- A misaligned `jr_target` is loaded unchanged. `pc_misalign_f` flags it while that address is in F. The block does not trap; the exception logic downstream owns that.

## Timing
- Reset, with `reset` sampled high on an edge:
  - `pc_f = RESET_PC`.
  - `pc_d = RESET_PC`.
  - `instr_d = NOP_WORD`.
  - `pc8_d = RESET_PC + 8`.
  - `pc_misalign_f = 0`, for the default `RESET_PC`.
- Reset has priority over `stall` and every redirect, including mid-stall and mid-branch.
- Fetch latency: an instruction presented on `instr_f` appears on `instr_d` one cycle later, absent stall.
- Branch/jump latency: a branch in D in cycle n makes `pc_f = target` in cycle n+1. The delay slot is in D in n+1, and the target instruction is in D in n+2.
- `stall` and a redirect in the same cycle: stall wins; PC is unchanged.
- `jr_en` and `j_en` both high is illegal decode; the priority above still applies deterministically.

## Configuration
- `BRANCH_LIKELY_EN` defined:
  - Port `likely_d` exists.
  - On a non-stall edge with `likely_d=1` and `cmp_allow=0`: `instr_d <= NOP_WORD`, `pc_d <= pc_f`. The delay slot is annulled while its PC is kept for debug, and `pc_f <= pc_f + 4`.
  - Stall still takes priority over the annul.
- `BRANCH_LIKELY_EN` undefined:
  - No `likely_d` port.
  - The delay slot always executes.

## Test plan
- Reset, then free-run 4 cycles with no redirect:
  - `pc_f` steps 0x3000, 0x3004, 0x3008, 0x300C.
  - `instr_d` is NOP in the first cycle, then follows IM with a 1-cycle lag.
- Taken branch with `pc_d = 0x3008`, `imm16_d = 16'hFFFE`, `cmp_allow = 1`:
  - Next `pc_f = 0x3004`.
  - The delay slot at 0x300C reaches D.
  - `pc8_d` was 0x3010 during the branch cycle.
- `stall` held 3 cycles while `j_en = 1`, `index26_d = 26'h0000C00`, `pc_d = 0x3010`:
  - PC frozen at 0x3018.
  - On stall release `pc_f = 0x3000`, taken exactly once.
- `jr_en = 1` with `jr_target = 0x0000_3002`:
  - `pc_f = 0x3002` and `pc_misalign_f = 1`.
  - `jr_en` beats a simultaneous `cmp_allow = 1`.
- `reset` asserted in the same cycle as a taken branch and `stall`:
  - Outputs return to the reset values above.
- With `BRANCH_LIKELY_EN`, `likely_d = 1`, `cmp_allow = 0`:
  - `instr_d = NOP_WORD` next cycle.
  - `pc_f` advances by 4.
  - With `cmp_allow = 1`, the delay slot executes normally.
